// File: rtl/exec_cdb_arbiter.sv
// Round-robin arbiter sharing the single CDB writeback slot between NUM_REQ
// execute units, each fronted by a one-entry holding buffer with back-pressure.
module exec_cdb_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ROBsize    = 32,
  parameter int ROBsizeLog = $clog2(ROBsize + 1),
  parameter int SRCW       = $clog2(NUM_REQ)
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          flush_i,
  input  logic                          cdbStall_i,
  input  logic [NUM_REQ-1:0]            valid_i,
  input  logic [NUM_REQ*ROBsizeLog-1:0] tag_i,
  input  logic [NUM_REQ*64-1:0]         val_i,
  input  logic [NUM_REQ*4-1:0]          flags_i,
  output logic [NUM_REQ-1:0]            canGo_o,
  output logic                          cdbValid_o,
  output logic [ROBsizeLog-1:0]         cdbTag_o,
  output logic [63:0]                   cdbVal_o,
  output logic [3:0]                    cdbFlags_o,
  output logic [SRCW-1:0]               cdbSrc_o
);

  logic [NUM_REQ-1:0]    held;
  logic [ROBsizeLog-1:0] hTag   [NUM_REQ];
  logic [63:0]           hVal   [NUM_REQ];
  logic [3:0]            hFlags [NUM_REQ];
  logic [SRCW-1:0]       rrPtr;

  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    capture;
  logic                  found;
  logic [SRCW-1:0]       winner;
  logic [SRCW-1:0]       cand;
  logic [SRCW-1:0]       nextPtr;

  // Winner search starts at rrPtr and wraps; stall and flush suppress any grant.
  always_comb begin
    grant  = '0;
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    if (!cdbStall_i && !flush_i) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = SRCW'((int'(rrPtr) + k) % NUM_REQ);
        if (!found && held[cand]) begin
          found  = 1'b1;
          winner = cand;
        end
      end
    end
    if (found) grant[winner] = 1'b1;
  end

  // A granted buffer frees this cycle, so its unit may refill back-to-back.
  assign canGo_o = flush_i ? '0 : (~held | grant);
  assign capture = valid_i & canGo_o;
  assign nextPtr = (winner == SRCW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

  // Stage boundary: holding buffers capture presented results.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (capture[i]) begin
        hTag[i]   <= tag_i[i*ROBsizeLog +: ROBsizeLog];
        hVal[i]   <= val_i[i*64 +: 64];
        hFlags[i] <= flags_i[i*4 +: 4];
      end
    end
  end

  // Stage boundary: winning buffer is registered onto the CDB.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      held       <= '0;
      rrPtr      <= '0;
      cdbValid_o <= 1'b0;
      cdbTag_o   <= '0;
      cdbVal_o   <= '0;
      cdbFlags_o <= '0;
      cdbSrc_o   <= '0;
    end else begin
      held       <= flush_i ? '0 : ((held & ~grant) | capture);
      cdbValid_o <= found;
      if (found) begin
        rrPtr      <= nextPtr;
        cdbTag_o   <= hTag[winner];
        cdbVal_o   <= hVal[winner];
        cdbFlags_o <= hFlags[winner];
        cdbSrc_o   <= winner;
      end
    end
  end

endmodule

// File: tb/tb_exec_cdb_arbiter.sv
// Randomized scoreboard bench for exec_cdb_arbiter: a queue-based reference
// model predicts canGo and every CDB broadcast; a monitor checks the outputs.
module tb_exec_cdb_arbiter;

  localparam int N  = 4;
  localparam int TW = $clog2(32 + 1);
  localparam int SW = $clog2(N);

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic              flush_i;
  logic              cdbStall_i;
  logic [N-1:0]      valid_i;
  logic [N*TW-1:0]   tag_i;
  logic [N*64-1:0]   val_i;
  logic [N*4-1:0]    flags_i;
  logic [N-1:0]      canGo_o;
  logic              cdbValid_o;
  logic [TW-1:0]     cdbTag_o;
  logic [63:0]       cdbVal_o;
  logic [3:0]        cdbFlags_o;
  logic [SW-1:0]     cdbSrc_o;

  exec_cdb_arbiter #(.NUM_REQ(N), .ROBsize(32)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i), .cdbStall_i(cdbStall_i),
    .valid_i(valid_i), .tag_i(tag_i), .val_i(val_i), .flags_i(flags_i),
    .canGo_o(canGo_o), .cdbValid_o(cdbValid_o), .cdbTag_o(cdbTag_o),
    .cdbVal_o(cdbVal_o), .cdbFlags_o(cdbFlags_o), .cdbSrc_o(cdbSrc_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          cyc;
    logic [TW-1:0] tag;
    logic [63:0] val;
    logic [3:0]  fl;
    int          src;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;
  int drvCyc = 0;
  int monCyc = 0;

  // Reference model: per-unit occupancy and a round-robin start index.
  bit            mHeld [N];
  logic [TW-1:0] mTag  [N];
  logic [63:0]   mVal  [N];
  logic [3:0]    mFl   [N];
  int            mRr;

  // Transactions each unit is currently presenting (held stable until accepted).
  bit            pv   [N];
  logic [TW-1:0] pt   [N];
  logic [63:0]   pval [N];
  logic [3:0]    pf   [N];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h at t=%0t", name, got, want, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #2;
    drvCyc++;
  endtask

  task automatic newTx(input int i, input logic [TW-1:0] t, input logic [63:0] v, input logic [3:0] f);
    pv[i] = 1'b1; pt[i] = t; pval[i] = v; pf[i] = f;
  endtask

  task automatic drive(input bit st, input bit fl, input string name);
    int w;
    logic [N-1:0] go;
    cdbStall_i = st;
    flush_i    = fl;
    for (int i = 0; i < N; i++) begin
      valid_i[i]          = pv[i];
      tag_i[i*TW +: TW]   = pt[i];
      val_i[i*64 +: 64]   = pval[i];
      flags_i[i*4 +: 4]   = pf[i];
    end
    w = -1;
    if (!st && !fl) begin
      for (int k = 0; k < N; k++) begin
        int u = (mRr + k) % N;
        if (w < 0 && mHeld[u]) w = u;
      end
    end
    for (int i = 0; i < N; i++) go[i] = !fl && (!mHeld[i] || i == w);
    #1;
    check({name, " canGo"}, 64'(canGo_o), 64'(go));
    if (fl) begin
      for (int i = 0; i < N; i++) mHeld[i] = 1'b0;
    end else begin
      if (w >= 0) begin
        q.push_back('{drvCyc + 1, mTag[w], mVal[w], mFl[w], w});
        mHeld[w] = 1'b0;
        mRr = (w + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
        if (pv[i] && go[i]) begin
          mHeld[i] = 1'b1; mTag[i] = pt[i]; mVal[i] = pval[i]; mFl[i] = pf[i];
          pv[i] = 1'b0;
        end
      end
    end
    step();
  endtask

  task automatic doReset();
    reset_i = 1'b1; flush_i = 1'b0; cdbStall_i = 1'b0;
    valid_i = '0; tag_i = '0; val_i = '0; flags_i = '0;
    for (int i = 0; i < N; i++) begin
      mHeld[i] = 1'b0; pv[i] = 1'b0;
    end
    mRr = 0;
    q.delete();
    step();
    step();
    reset_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) drive(1'b0, 1'b0, "idle");
  endtask

  // Monitor: one sample per cycle, 1 time unit after the rising edge.
  initial begin : monitor
    logic [TW-1:0] lastTag;
    logic [63:0]   lastVal;
    bit            expV;
    exp_t          e;
    lastTag = '0;
    lastVal = '0;
    forever begin
      @(posedge clk_i);
      monCyc++;
      #1;
      if (reset_i) begin
        check("rst cdbValid", 64'(cdbValid_o), 64'd0);
        check("rst cdbTag",   64'(cdbTag_o),   64'd0);
        check("rst cdbVal",   cdbVal_o,        64'd0);
        check("rst cdbFlags", 64'(cdbFlags_o), 64'd0);
        check("rst cdbSrc",   64'(cdbSrc_o),   64'd0);
        lastTag = '0;
        lastVal = '0;
      end else begin
        expV = (q.size() > 0) && (q[0].cyc == monCyc);
        check("cdbValid", 64'(cdbValid_o), 64'(expV));
        if (expV) begin
          e = q.pop_front();
          if (cdbValid_o) begin
            check("cdbTag",   64'(cdbTag_o),   64'(e.tag));
            check("cdbVal",   cdbVal_o,        e.val);
            check("cdbFlags", 64'(cdbFlags_o), 64'(e.fl));
            check("cdbSrc",   64'(cdbSrc_o),   64'(e.src));
          end
        end
        if (cdbValid_o) begin
          lastTag = cdbTag_o;
          lastVal = cdbVal_o;
        end else begin
          check("hold cdbTag", 64'(cdbTag_o), 64'(lastTag));
          check("hold cdbVal", cdbVal_o, lastVal);
        end
      end
    end
  end

  initial begin : driver
    doReset();

    // Single unit, tag 3, value 18
    newTx(0, TW'(3), 64'd18, 4'd0);
    drive(1'b0, 1'b0, "single");
    idle(3);

    // All four units continuously requesting from rrPtr=0
    doReset();
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < N; i++)
        if (!pv[i]) newTx(i, TW'(i + 1), 64'(100 * c + i), 4'(i));
      drive(1'b0, 1'b0, "rr");
    end
    idle(6);

    // Unit 1 streaming back-to-back tags 10..15
    for (int c = 0; c < 6; c++) begin
      newTx(1, TW'(10 + c), 64'(1000 + c), 4'hA);
      drive(1'b0, 1'b0, "stream");
    end
    idle(3);

    // ROB stall with units 0 and 2 held
    newTx(0, TW'(7), 64'h7777, 4'h3);
    newTx(2, TW'(9), 64'h9999, 4'h5);
    drive(1'b1, 1'b0, "stallcap");
    for (int c = 0; c < 3; c++) drive(1'b1, 1'b0, "stall");
    idle(3);

    // Flush with units 1 and 3 held and unit 0 presenting
    newTx(1, TW'(21), 64'h2121, 4'h1);
    newTx(3, TW'(23), 64'h2323, 4'h2);
    drive(1'b1, 1'b0, "flushcap");
    newTx(0, TW'(20), 64'h2020, 4'h4);
    drive(1'b0, 1'b1, "flush");
    drive(1'b0, 1'b0, "postflush");
    idle(3);

    // Reset mid-traffic with units 0 and 2 held
    newTx(0, TW'(30), 64'h3030, 4'h6);
    newTx(2, TW'(31), 64'h3131, 4'h7);
    drive(1'b1, 1'b0, "rstcap");
    doReset();
    idle(3);

    // Randomized traffic with stalls, flushes and occasional resets
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 249) == 0) begin
        doReset();
      end else begin
        for (int i = 0; i < N; i++)
          if (!pv[i] && $urandom_range(0, 2) != 0)
            newTx(i, TW'($urandom), {$urandom, $urandom}, 4'($urandom));
        drive($urandom_range(0, 4) == 0, $urandom_range(0, 29) == 0, "rand");
      end
    end
    for (int i = 0; i < N; i++) pv[i] = 1'b0;
    idle(6);
    check("drain", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
